cpc_video_fetch: RTL and testbench

CPC_VIDEO_FETCH -- requirements
Module: cpc_video_fetch

---
 rtl/cpc_video_pkg.sv | 40 ++++
 rtl/cpc_raster_int.sv | 70 +++++++
 rtl/cpc_video_fetch.sv | 130 +++++++++++++
 tb/tb_cpc_video_fetch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_video_pkg.sv
// Shared types and constants for the CPC video fetch path and raster interrupt.
package cpc_video_pkg;

   typedef enum logic [1:0] {
      M0 = 2'd0,
      M1 = 2'd1,
      M2 = 2'd2,
      M3 = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD0  = 2'd1,
      RD1  = 2'd2,
      DONE = 2'd3
   } fetch_state_t;

   localparam int INT_LINES    = 52;
   localparam int INT_VS_MIN   = 32;
   localparam int PIX_PER_CHAR = 16;

   // Pixel width minus one, in PIXEN pulses; widths are powers of two so this doubles as a mask.
   function automatic logic [3:0] pix_mask(input mode_t m);
      case (m)
         M2:      return 4'd0;
         M1:      return 4'd1;
         default: return 4'd3;
      endcase
   endfunction

   // Pen index from the top byte of the shifter, using the gate-array bit interleave.
   function automatic logic [3:0] decode_pen(input logic [7:0] hi, input mode_t m);
      case (m)
         M2:      return {3'b000, hi[7]};
         M0:      return {hi[1], hi[5], hi[3], hi[7]};
         default: return {2'b00, hi[3], hi[7]};
      endcase
   endfunction

endpackage

// File: rtl/cpc_raster_int.sv
// Raster interrupt generator: 52-line counter clocked by HSYNC falls, resynchronised by VSYNC.
module cpc_raster_int
   import cpc_video_pkg::*;
(
   input  logic CLOCK,
   input  logic nRESET,
   input  logic HSYNC,
   input  logic VSYNC,
   input  logic INT_ACK,
   input  logic CLR_R52,
   output logic INT
);

   logic       hsync_q;
   logic       vsync_q;
   logic [5:0] r52;
   logic [5:0] r52_inc;
   logic [1:0] vs_pend;
   logic       hs_fall;
   logic       vs_rise;
   logic       vs_sync;

   assign hs_fall = hsync_q & ~HSYNC;
   assign vs_rise = VSYNC & ~vsync_q;
   assign r52_inc = r52 + 6'd1;
   // second HSYNC fall after a VSYNC rise resynchronises the counter to the frame
   assign vs_sync = hs_fall && (vs_pend == 2'd1);

   // Edge detection, VSYNC countdown, line counter and interrupt flag
   always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
         vs_pend <= 2'd0;
         r52     <= 6'd0;
         INT     <= 1'b0;
      end else begin
         hsync_q <= HSYNC;
         vsync_q <= VSYNC;

         if (vs_rise)
            vs_pend <= 2'd2;
         else if (hs_fall && vs_pend != 2'd0)
            vs_pend <= vs_pend - 2'd1;

         if (CLR_R52) begin
            r52 <= 6'd0;
            INT <= 1'b0;
         end else if (vs_sync) begin
            r52 <= 6'd0;
            if (r52 >= 6'(INT_VS_MIN))
               INT <= 1'b1;
            else if (INT_ACK)
               INT <= 1'b0;
         end else if (hs_fall && r52_inc == 6'(INT_LINES)) begin
            // wrap takes priority over a coincident acknowledge
            r52 <= 6'd0;
            INT <= 1'b1;
         end else begin
            if (hs_fall)
               r52 <= INT_ACK ? (r52_inc & 6'b011111) : r52_inc;
            else if (INT_ACK)
               r52 <= r52 & 6'b011111;
            if (INT_ACK)
               INT <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cpc_video_fetch.sv
// CPC video fetch: two-byte RAM fetch per character, pixel shifter/decoder, raster interrupt.
//
// state | meaning
// IDLE  | no fetch in progress (also entered on abort)
// RD0   | RAM_RD high, requesting first byte of the character
// RD1   | RAM_RD high, requesting second byte of the character
// DONE  | both bytes captured, waiting for the next CLKEN to hand them to the shifter
//
// A fetch still incomplete at CLKEN is abandoned; that CLKEN does not start a new
// fetch either, so RAM_RD is guaranteed to drop for at least one character.
module cpc_video_fetch
   import cpc_video_pkg::*;
(
   input  logic        CLOCK,
   input  logic        nRESET,
   input  logic        CLKEN,
   input  logic        PIXEN,
   input  logic [13:0] MA,
   input  logic [4:0]  RA,
   input  logic        DE,
   input  logic        HSYNC,
   input  logic        VSYNC,
   input  logic [1:0]  MODE,
   output logic [15:0] RAM_ADDR,
   output logic        RAM_RD,
   input  logic        RAM_ACK,
   input  logic [7:0]  RAM_DATA,
   output logic [3:0]  PEN,
   output logic        BORDER,
   output logic        INT,
   input  logic        INT_ACK,
   input  logic        CLR_R52
);

   fetch_state_t state;
   logic [7:0]   byte0;
   logic [7:0]   byte1;
   logic         fetch_de;
   logic         de_dly;
   logic [15:0]  shifter;
   logic [3:0]   pix_cnt;
   logic [3:0]   pix_nxt;
   mode_t        mode_eff;
   logic         hsync_q;
   logic         unused_addr_bits;

   assign unused_addr_bits = ^{MA[11:10], RA[4:3]};
   assign pix_nxt          = pix_cnt + 4'd1;

   // Fetch sequencer: starts on CLKEN with DE, walks both bytes, aborts if CLKEN arrives early
   always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
         state    <= IDLE;
         RAM_RD   <= 1'b0;
         RAM_ADDR <= 16'h0000;
         byte0    <= 8'h00;
         byte1    <= 8'h00;
      end else if (CLKEN) begin
         if (state == RD0 || state == RD1) begin
            state  <= IDLE;
            RAM_RD <= 1'b0;
         end else if (DE) begin
            state    <= RD0;
            RAM_RD   <= 1'b1;
            RAM_ADDR <= {MA[13:12], RA[2:0], MA[9:0], 1'b0};
         end else begin
            state <= IDLE;
         end
      end else begin
         case (state)
            RD0: if (RAM_ACK) begin
               byte0       <= RAM_DATA;
               RAM_ADDR[0] <= 1'b1;
               state       <= RD1;
            end
            RD1: if (RAM_ACK) begin
               byte1  <= RAM_DATA;
               RAM_RD <= 1'b0;
               state  <= DONE;
            end
            default: ;
         endcase
      end
   end

   // Pixel shifter: loads last character's bytes at CLKEN, shifts once per pixel width
   always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
         shifter  <= 16'h0000;
         pix_cnt  <= 4'd0;
         fetch_de <= 1'b0;
         de_dly   <= 1'b0;
      end else if (CLKEN) begin
         shifter  <= (state == DONE) ? {byte0, byte1} : 16'h0000;
         pix_cnt  <= 4'd0;
         fetch_de <= DE;
         de_dly   <= fetch_de;
      end else if (PIXEN) begin
         pix_cnt <= pix_nxt;
         if ((pix_nxt & pix_mask(mode_eff)) == 4'd0)
            shifter <= {shifter[14:0], 1'b0};
      end
   end

   // Screen mode takes effect only at the start of a line (HSYNC rise)
   always_ff @(posedge CLOCK) begin
      if (!nRESET) begin
         hsync_q  <= 1'b0;
         mode_eff <= M1;
      end else begin
         hsync_q <= HSYNC;
         if (HSYNC && !hsync_q)
            mode_eff <= mode_t'(MODE);
      end
   end

   assign PEN    = de_dly ? decode_pen(shifter[15:8], mode_eff) : 4'h0;
   assign BORDER = ~de_dly;

   cpc_raster_int u_raster_int (
      .CLOCK   (CLOCK),
      .nRESET  (nRESET),
      .HSYNC   (HSYNC),
      .VSYNC   (VSYNC),
      .INT_ACK (INT_ACK),
      .CLR_R52 (CLR_R52),
      .INT     (INT)
   );

endmodule

// File: tb/tb_cpc_video_fetch.sv
// Scoreboard bench for cpc_video_fetch: random characters through a RAM model, pixel and
// address expectations queued by stimulus and popped by monitors; raster interrupt model.
module tb_cpc_video_fetch;

   logic        CLOCK = 1'b0;
   logic        nRESET = 1'b0;
   logic        CLKEN = 1'b0;
   logic        PIXEN = 1'b1;
   logic [13:0] MA = '0;
   logic [4:0]  RA = '0;
   logic        DE = 1'b0;
   logic        HSYNC = 1'b0;
   logic        VSYNC = 1'b0;
   logic [1:0]  MODE = 2'd1;
   logic [15:0] RAM_ADDR;
   logic        RAM_RD;
   logic        RAM_ACK = 1'b0;
   logic [7:0]  RAM_DATA = '0;
   logic [3:0]  PEN;
   logic        BORDER;
   logic        INT;
   logic        INT_ACK = 1'b0;
   logic        CLR_R52 = 1'b0;

   cpc_video_fetch dut (
      .CLOCK(CLOCK), .nRESET(nRESET), .CLKEN(CLKEN), .PIXEN(PIXEN),
      .MA(MA), .RA(RA), .DE(DE), .HSYNC(HSYNC), .VSYNC(VSYNC), .MODE(MODE),
      .RAM_ADDR(RAM_ADDR), .RAM_RD(RAM_RD), .RAM_ACK(RAM_ACK), .RAM_DATA(RAM_DATA),
      .PEN(PEN), .BORDER(BORDER), .INT(INT), .INT_ACK(INT_ACK), .CLR_R52(CLR_R52)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct {logic [3:0] pen; logic border;} pix_t;
   typedef struct {bit de; bit ok; logic [15:0] word;} chr_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   pix_t        pix_q[$];
   logic [15:0] addr_q[$];
   pix_t        mon_e;
   logic [7:0]  cur_b0 = 8'h00;
   logic [7:0]  cur_b1 = 8'h00;
   bit          stall = 1'b0;
   int          wait_cnt = 0;
   bit          chk_low = 1'b0;
   chr_t        prev = '{de: 1'b0, ok: 1'b0, word: 16'h0};
   bit          prev_stall = 1'b0;
   int          model_mode = 1;
   int          r_mdl = 0;
   bit          int_mdl = 1'b0;
   int          vs_pend_mdl = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pixel k (0..15 PIXEN pulses into the character) of a 16-bit character word.
   function automatic logic [3:0] pen_model(input logic [15:0] word, input int mode, input int k);
      int          per;
      logic [15:0] w;
      per = (mode == 2) ? 1 : (mode == 1) ? 2 : 4;
      w   = word << (k / per);
      case (mode)
         2:       return {3'b000, w[15]};
         0:       return {w[9], w[13], w[11], w[15]};
         default: return {2'b00, w[11], w[15]};
      endcase
   endfunction

   // Pixel monitor: one expectation per PIXEN cycle once the scoreboard has entries
   always @(posedge CLOCK) begin
      #1;
      if (pix_q.size() > 0) begin
         mon_e = pix_q.pop_front();
         check("pen", PEN, mon_e.pen);
         check("border", BORDER, mon_e.border);
      end
   end

   // RAM model and address monitor: random ack latency, no ack while stalled
   always @(posedge CLOCK) begin
      #3;
      if (chk_low) begin
         check("rd_low_after_ack1", RAM_RD, 0);
         chk_low = 1'b0;
      end
      RAM_ACK = 1'b0;
      if (!RAM_RD) begin
         wait_cnt = $urandom_range(0, 3);
      end else if (!stall) begin
         if (wait_cnt == 0) begin
            RAM_ACK  = 1'b1;
            RAM_DATA = RAM_ADDR[0] ? cur_b1 : cur_b0;
            if (addr_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL ram_addr: unexpected read of %0h, nothing expected", RAM_ADDR);
            end else begin
               check("ram_addr", RAM_ADDR, addr_q.pop_front());
            end
            if (RAM_ADDR[0]) chk_low = 1'b1;
            wait_cnt = $urandom_range(0, 3);
         end else begin
            wait_cnt--;
         end
      end
   end

   // One character period (16 cycles); queues the display of the previous character.
   task automatic char_step(input bit de, input logic [13:0] ma, input logic [4:0] ra,
                            input logic [7:0] b0, input logic [7:0] b1, input bit st,
                            input bit hs, input int new_mode);
      pix_t p;
      bit   started;
      bit   ok;
      @(negedge CLOCK);
      for (int k = 0; k < 16; k++) begin
         if (!prev.de) p = '{pen: 4'h0, border: 1'b1};
         else          p = '{pen: pen_model(prev.ok ? prev.word : 16'h0, model_mode, k), border: 1'b0};
         pix_q.push_back(p);
      end
      started = de && !prev_stall;
      ok      = started && !st;
      if (ok) begin
         addr_q.push_back({ma[13:12], ra[2:0], ma[9:0], 1'b0});
         addr_q.push_back({ma[13:12], ra[2:0], ma[9:0], 1'b1});
      end
      CLKEN = 1'b1; DE = de; MA = ma; RA = ra;
      cur_b0 = b0; cur_b1 = b1; stall = st;
      prev       = '{de: de, ok: ok, word: {b0, b1}};
      prev_stall = started && st;
      for (int j = 1; j < 16; j++) begin
         @(negedge CLOCK);
         CLKEN = 1'b0;
         if (hs && j == 2) begin
            HSYNC = 1'b1;
            MODE  = 2'(new_mode);
         end
         if (hs && j == 4) begin
            HSYNC      = 1'b0;
            model_mode = new_mode;
         end
      end
   endtask

   task automatic hs_pulse(input bit ack, input bit clr);
      @(negedge CLOCK) HSYNC = 1'b1;
      @(negedge CLOCK);
      @(negedge CLOCK) begin HSYNC = 1'b0; INT_ACK = ack; CLR_R52 = clr; end
      @(negedge CLOCK) begin INT_ACK = 1'b0; CLR_R52 = 1'b0; end
      if (clr) begin
         r_mdl = 0; int_mdl = 1'b0;
         if (vs_pend_mdl > 0) vs_pend_mdl--;
      end else if (vs_pend_mdl == 1) begin
         vs_pend_mdl = 0;
         if (r_mdl >= 32) int_mdl = 1'b1;
         else if (ack)    int_mdl = 1'b0;
         r_mdl = 0;
      end else begin
         if (vs_pend_mdl == 2) vs_pend_mdl = 1;
         r_mdl++;
         if (r_mdl == 52) begin
            r_mdl = 0; int_mdl = 1'b1;
         end else if (ack) begin
            int_mdl = 1'b0; r_mdl = r_mdl % 32;
         end
      end
      @(negedge CLOCK);
      check("int", INT, int_mdl);
   endtask

   task automatic hs_run(input int n);
      for (int i = 0; i < n; i++) hs_pulse(1'b0, 1'b0);
   endtask

   task automatic ack_only();
      @(negedge CLOCK) INT_ACK = 1'b1;
      @(negedge CLOCK) INT_ACK = 1'b0;
      int_mdl = 1'b0;
      r_mdl   = r_mdl % 32;
      check("int_after_ack", INT, int_mdl);
   endtask

   task automatic clr_only();
      @(negedge CLOCK) CLR_R52 = 1'b1;
      @(negedge CLOCK) CLR_R52 = 1'b0;
      int_mdl = 1'b0;
      r_mdl   = 0;
      check("int_after_clr", INT, int_mdl);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          order[4];
      int          m;
      bit          de;
      bit          st;
      logic [13:0] ma;
      logic [4:0]  ra;
      logic [7:0]  b0;
      logic [7:0]  b1;
      order = '{2, 0, 1, 3};

      repeat (4) @(negedge CLOCK);
      check("rst_ram_rd", RAM_RD, 0);
      check("rst_ram_addr", RAM_ADDR, 0);
      check("rst_pen", PEN, 0);
      check("rst_border", BORDER, 1);
      check("rst_int", INT, 0);
      nRESET = 1'b1;

      for (int blk = 0; blk < 7; blk++) begin
         m = (blk < 4) ? order[blk] : int'($urandom_range(0, 3));
         char_step(1'b0, 14'h0, 5'h0, 8'h0, 8'h0, 1'b0, 1'b0, m);
         char_step(1'b0, 14'h0, 5'h0, 8'h0, 8'h0, 1'b0, 1'b1, m);
         for (int c = 0; c < 10; c++) begin
            de = (c == 0) || ($urandom_range(0, 3) != 0);
            ma = 14'($urandom);
            ra = 5'($urandom);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            st = (c >= 2) && ($urandom_range(0, 5) == 0);
            if (c == 0) begin
               if (blk == 0) begin ma = 14'h3000; ra = 5'd2; end
               if (m == 2) begin b0 = 8'h80; b1 = 8'h01; end
               if (m == 0) begin b0 = 8'hAA; b1 = 8'h55; end
            end
            if (blk == 1 && c >= 4 && c <= 6) begin
               de = 1'b1;
               st = (c == 4);
            end
            char_step(de, ma, ra, b0, b1, st, 1'b0, m);
         end
      end
      char_step(1'b0, 14'h0, 5'h0, 8'h0, 8'h0, 1'b0, 1'b0, model_mode);
      repeat (17) @(negedge CLOCK);
      check("pix_queue_drained", pix_q.size(), 0);
      check("addr_queue_drained", addr_q.size(), 0);

      // reset in the middle of a stalled fetch
      @(negedge CLOCK) begin CLKEN = 1'b1; DE = 1'b1; MA = 14'h1234; RA = 5'd1; stall = 1'b1; end
      @(negedge CLOCK) CLKEN = 1'b0;
      @(negedge CLOCK);
      @(negedge CLOCK);
      check("rd_before_reset", RAM_RD, 1);
      nRESET = 1'b0;
      @(posedge CLOCK);
      #1;
      check("rst_mid_ram_rd", RAM_RD, 0);
      check("rst_mid_ram_addr", RAM_ADDR, 0);
      check("rst_mid_border", BORDER, 1);
      @(negedge CLOCK) begin nRESET = 1'b1; stall = 1'b0; DE = 1'b0; end

      // raster interrupt
      hs_run(52);
      ack_only();
      hs_run(51);
      hs_pulse(1'b1, 1'b0);
      ack_only();
      hs_run(40);
      ack_only();
      hs_run(44);
      ack_only();
      clr_only();
      hs_run(40);
      @(negedge CLOCK) VSYNC = 1'b1;
      vs_pend_mdl = 2;
      hs_run(2);
      @(negedge CLOCK) VSYNC = 1'b0;
      ack_only();
      hs_run(20);
      @(negedge CLOCK) VSYNC = 1'b1;
      vs_pend_mdl = 2;
      hs_run(2);
      @(negedge CLOCK) VSYNC = 1'b0;
      hs_run(52);
      ack_only();
      hs_run(10);
      hs_pulse(1'b0, 1'b1);
      hs_run(52);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
